lane_shifter: RTL and testbench

Per-lane obstacle scroller for the Frogger playfield. It consumes the one-cycle tick pulse produced by the upstream tick counter and rotates the lane's obstacle bit pattern one cell per N ticks. The rotation direction and speed are programmable. It also reports a registered collision flag for the frog's column. One instance per lane; the renderer and the game-control FSM sit downstream.

---
 rtl/lane_shifter.sv | 135 +++++++++++++
 tb/tb_lane_shifter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/lane_shifter.sv
// lane_shifter: per-lane obstacle scroller for the Frogger playfield.
// Rotates the lane's obstacle pattern one cell every speed+1 qualified ticks,
// accepts new patterns through a valid/ready load port, counts full lane
// revolutions and reports a registered collision flag for the frog's column.
module lane_shifter #(
  parameter int                    LANE_WIDTH   = 16,
  parameter int                    COL_WIDTH    = 4,
  parameter int                    SPEED_WIDTH  = 4,
  parameter logic [LANE_WIDTH-1:0] INIT_PATTERN = 16'h0F0F,
  parameter bit                    DIR_LEFT     = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   tick_i,
  input  logic                   en_i,
  input  logic [SPEED_WIDTH-1:0] speed_i,
  input  logic                   load_valid_i,
  input  logic [LANE_WIDTH-1:0]  load_pattern_i,
  output logic                   load_ready_o,
  input  logic [COL_WIDTH-1:0]   frog_col_i,
  output logic [LANE_WIDTH-1:0]  pattern_o,
  output logic                   shift_pulse_o,
  output logic                   hit_o,
  output logic [7:0]             wrap_count_o
);

  localparam int                OFF_W    = (LANE_WIDTH > 2) ? $clog2(LANE_WIDTH) : 1;
  localparam logic [OFF_W-1:0]  OFF_LAST = OFF_W'(LANE_WIDTH - 1);

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [LANE_WIDTH-1:0]  pattern_q, pattern_d;
  logic [SPEED_WIDTH-1:0] tick_cnt_q, tick_cnt_d;
  logic [OFF_W-1:0]       offset_q, offset_d;
  logic [7:0]             wrap_q, wrap_d;
  logic                   shift_pulse_q, hit_q, hit_d;
  logic                   load_ready;
  logic                   load_accept;
  logic                   tick_qual;
  logic                   do_shift;
  logic [LANE_WIDTH-1:0]  rotated;

  assign load_accept = load_valid_i && load_ready;

  // State register: RUN after reset, HOLD lasts one cycle after a load.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours, regardless of block order.
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  // Next-state logic: a load sends RUN to HOLD, HOLD always returns to RUN.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (load_accept) state_d = HOLD;
      HOLD:    state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // Output logic: loads are only offered while scrolling.
  always_comb begin
    load_ready = (state_q == RUN);
  end

  // Datapath next-state: load beats shift, prescaler frozen unless tick && en in RUN.
  always_comb begin
    // NOTE: every combinational output gets a default first; a path that
    // leaves one unassigned would otherwise infer a latch.
    pattern_d  = pattern_q;
    tick_cnt_d = tick_cnt_q;
    offset_d   = offset_q;
    wrap_d     = wrap_q;
    do_shift   = 1'b0;

    rotated   = DIR_LEFT ? {pattern_q[LANE_WIDTH-2:0], pattern_q[LANE_WIDTH-1]}
                         : {pattern_q[0], pattern_q[LANE_WIDTH-1:1]};
    tick_qual = tick_i && en_i && (state_q == RUN);

    if (load_accept) begin
      pattern_d  = load_pattern_i;
      tick_cnt_d = '0;
      offset_d   = '0;
    end else if (tick_qual) begin
      // >= rather than == so lowering speed mid-count shifts on the next tick.
      if (tick_cnt_q >= speed_i) begin
        do_shift   = 1'b1;
        pattern_d  = rotated;
        tick_cnt_d = '0;
        if (offset_q == OFF_LAST) begin
          offset_d = '0;
          wrap_d   = wrap_q + 8'd1;
        end else begin
          offset_d = offset_q + 1'b1;
        end
      end else begin
        tick_cnt_d = tick_cnt_q + 1'b1;
      end
    end

    hit_d = (int'(frog_col_i) < LANE_WIDTH) ? pattern_q[frog_col_i] : 1'b0;
  end

  // Datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pattern_q     <= INIT_PATTERN;
      tick_cnt_q    <= '0;
      offset_q      <= '0;
      wrap_q        <= '0;
      shift_pulse_q <= 1'b0;
      hit_q         <= 1'b0;
    end else begin
      pattern_q     <= pattern_d;
      tick_cnt_q    <= tick_cnt_d;
      offset_q      <= offset_d;
      wrap_q        <= wrap_d;
      shift_pulse_q <= do_shift;
      hit_q         <= hit_d;
    end
  end

  assign load_ready_o  = load_ready;
  assign pattern_o     = pattern_q;
  assign shift_pulse_o = shift_pulse_q;
  assign hit_o         = hit_q;
  assign wrap_count_o  = wrap_q;

endmodule

// File: tb/tb_lane_shifter.sv
// tb_lane_shifter: directed scenarios plus randomized traffic for lane_shifter,
// checked against a cycle-level behavioural model of the lane.
module tb_lane_shifter;

  localparam int LW = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tick_i = 1'b0;
  logic        en_i = 1'b1;
  logic [3:0]  speed_i = 4'd0;
  logic        load_valid_i = 1'b0;
  logic [15:0] load_pattern_i = 16'h0;
  logic        load_ready_o;
  logic [3:0]  frog_col_i = 4'd0;
  logic [15:0] pattern_o;
  logic        shift_pulse_o;
  logic        hit_o;
  logic [7:0]  wrap_count_o;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model state.
  logic [15:0] m_pattern;
  int          m_cnt, m_shifts_since_load, m_wrap;
  bit          m_hold, m_pulse, m_hit;

  lane_shifter #(
    .LANE_WIDTH(16), .COL_WIDTH(4), .SPEED_WIDTH(4),
    .INIT_PATTERN(16'h0F0F), .DIR_LEFT(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .tick_i(tick_i), .en_i(en_i), .speed_i(speed_i),
    .load_valid_i(load_valid_i), .load_pattern_i(load_pattern_i),
    .load_ready_o(load_ready_o), .frog_col_i(frog_col_i),
    .pattern_o(pattern_o), .shift_pulse_o(shift_pulse_o), .hit_o(hit_o),
    .wrap_count_o(wrap_count_o)
  );

  always #5 clk = ~clk;

  // Advance the model by one clock edge using the inputs presented at that edge.
  task automatic model_update();
    bit new_hit;
    new_hit = (int'(frog_col_i) < LW) ? ((m_pattern >> frog_col_i) & 16'h1) != 0 : 1'b0;
    if (rst) begin
      m_pattern = 16'h0F0F; m_cnt = 0; m_shifts_since_load = 0; m_wrap = 0;
      m_hold = 0; m_pulse = 0; m_hit = 0;
    end else begin
      m_pulse = 0;
      if (load_valid_i && !m_hold) begin
        m_pattern = load_pattern_i; m_cnt = 0; m_shifts_since_load = 0; m_hold = 1;
      end else begin
        if (tick_i && en_i && !m_hold) begin
          if (m_cnt >= int'(speed_i)) begin
            // Right rotation: cell 0 moves to cell 15.
            m_pattern = (m_pattern >> 1) | ((m_pattern & 16'h1) << 15);
            m_cnt = 0;
            m_pulse = 1;
            m_shifts_since_load++;
            if (m_shifts_since_load % LW == 0) m_wrap = (m_wrap + 1) % 256;
          end else begin
            m_cnt++;
          end
        end
        m_hold = 0;
      end
      m_hit = new_hit;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; tick_i = 0; load_valid_i = 0; en_i = 1; speed_i = 0; frog_col_i = 0;
    step();
    rst = 1'b0;
  endtask

  task automatic tick_once();
    tick_i = 1'b1; step(); tick_i = 1'b0;
  endtask

  task automatic load(input logic [15:0] p);
    load_valid_i = 1'b1; load_pattern_i = p; step(); load_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (pattern_o !== 16'h0F0F) begin n_bad++; $display("FAIL reset_pattern got %h want %h", pattern_o, 16'h0F0F); end
    n_cmp++; if (load_ready_o !== 1'b1) begin n_bad++; $display("FAIL reset_ready got %b want 1", load_ready_o); end
    n_cmp++; if (shift_pulse_o !== 1'b0 || hit_o !== 1'b0) begin n_bad++; $display("FAIL reset_pulse_hit got %b%b want 00", shift_pulse_o, hit_o); end
    n_cmp++; if (wrap_count_o !== 8'd0) begin n_bad++; $display("FAIL reset_wrap got %0d want 0", wrap_count_o); end
  endtask

  task automatic test_single_shift();
    do_reset();
    tick_once();
    n_cmp++; if (pattern_o !== 16'h8787) begin n_bad++; $display("FAIL single_shift_pattern got %h want %h", pattern_o, 16'h8787); end
    n_cmp++; if (shift_pulse_o !== 1'b1) begin n_bad++; $display("FAIL single_shift_pulse got %b want 1", shift_pulse_o); end
    step();
    n_cmp++; if (shift_pulse_o !== 1'b0) begin n_bad++; $display("FAIL single_shift_pulse_drop got %b want 0", shift_pulse_o); end
    n_cmp++; if (pattern_o !== m_pattern) begin n_bad++; $display("FAIL single_shift_hold got %h want %h", pattern_o, m_pattern); end
  endtask

  task automatic test_prescaler();
    int shifts, shift_mask;
    // Eight ticks, five cycles apart, speed 3: shifts after ticks 4 and 8.
    do_reset();
    speed_i = 4'd3;
    shifts = 0; shift_mask = 0;
    for (int i = 1; i <= 8; i++) begin
      tick_once();
      if (shift_pulse_o === 1'b1) begin shifts++; shift_mask |= (1 << i); end
      for (int k = 0; k < 4; k++) step();
    end
    n_cmp++; if (shift_mask !== ((1 << 4) | (1 << 8))) begin n_bad++; $display("FAIL prescaler_ticks got %h want %h", shift_mask, (1 << 4) | (1 << 8)); end
    n_cmp++; if (pattern_o !== m_pattern) begin n_bad++; $display("FAIL prescaler_pattern got %h want %h", pattern_o, m_pattern); end
    // Same again with en low for ticks 5 and 6: second shift moves to tick 10.
    do_reset();
    speed_i = 4'd3;
    shift_mask = 0;
    for (int i = 1; i <= 10; i++) begin
      en_i = (i == 5 || i == 6) ? 1'b0 : 1'b1;
      tick_once();
      if (shift_pulse_o === 1'b1) shift_mask |= (1 << i);
      en_i = 1'b1;
      for (int k = 0; k < 4; k++) step();
    end
    n_cmp++; if (shift_mask !== ((1 << 4) | (1 << 10))) begin n_bad++; $display("FAIL prescaler_en_ticks got %h want %h", shift_mask, (1 << 4) | (1 << 10)); end
  endtask

  task automatic test_load_vs_tick();
    do_reset();
    tick_i = 1'b1; load_valid_i = 1'b1; load_pattern_i = 16'h0001;
    step();
    load_valid_i = 1'b0;
    n_cmp++; if (pattern_o !== 16'h0001) begin n_bad++; $display("FAIL load_tick_pattern got %h want 0001", pattern_o); end
    n_cmp++; if (shift_pulse_o !== 1'b0) begin n_bad++; $display("FAIL load_tick_pulse got %b want 0", shift_pulse_o); end
    n_cmp++; if (load_ready_o !== 1'b0) begin n_bad++; $display("FAIL load_tick_ready got %b want 0", load_ready_o); end
    step(); // tick still high: arrives during HOLD and is lost
    tick_i = 1'b0;
    n_cmp++; if (pattern_o !== 16'h0001 || shift_pulse_o !== 1'b0) begin n_bad++; $display("FAIL hold_tick got %h/%b want 0001/0", pattern_o, shift_pulse_o); end
    n_cmp++; if (load_ready_o !== 1'b1) begin n_bad++; $display("FAIL hold_ready_back got %b want 1", load_ready_o); end
  endtask

  task automatic test_wrap();
    do_reset();
    load(16'h0001);
    step();
    tick_i = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      step();
      if (i % 16 == 0) begin
        n_cmp++; if (pattern_o !== 16'h0001) begin n_bad++; $display("FAIL wrap_return tick %0d got %h want 0001", i, pattern_o); end
      end
    end
    n_cmp++; if (wrap_count_o !== 8'd2) begin n_bad++; $display("FAIL wrap_two got %0d want 2", wrap_count_o); end
    for (int i = 0; i < 254 * 16; i++) step();
    tick_i = 1'b0;
    n_cmp++; if (wrap_count_o !== 8'd0 || wrap_count_o !== 8'(m_wrap)) begin n_bad++; $display("FAIL wrap_256 got %0d want 0", wrap_count_o); end
  endtask

  task automatic test_hit();
    do_reset();
    frog_col_i = 4'd0;
    load(16'h0001);
    step();
    n_cmp++; if (hit_o !== 1'b1) begin n_bad++; $display("FAIL hit_col0 got %b want 1", hit_o); end
    tick_once();
    n_cmp++; if (hit_o !== 1'b1) begin n_bad++; $display("FAIL hit_lag got %b want 1", hit_o); end
    step();
    n_cmp++; if (hit_o !== 1'b0) begin n_bad++; $display("FAIL hit_after_shift got %b want 0", hit_o); end
    frog_col_i = 4'd15;
    step();
    n_cmp++; if (hit_o !== 1'b1 || pattern_o !== 16'h8000) begin n_bad++; $display("FAIL hit_col15 got %b/%h want 1/8000", hit_o, pattern_o); end
  endtask

  task automatic test_rst_mid_hold();
    do_reset();
    speed_i = 4'd0;
    tick_once();
    load(16'hA5A5);
    load_valid_i = 1'b1; load_pattern_i = 16'h1234; rst = 1'b1; tick_i = 1'b1;
    step();
    rst = 1'b0; load_valid_i = 1'b0; tick_i = 1'b0;
    n_cmp++; if (pattern_o !== 16'h0F0F) begin n_bad++; $display("FAIL rst_hold_pattern got %h want 0F0F", pattern_o); end
    n_cmp++; if (load_ready_o !== 1'b1 || shift_pulse_o !== 1'b0 || hit_o !== 1'b0 || wrap_count_o !== 8'd0) begin
      n_bad++; $display("FAIL rst_hold_outputs got rdy=%b pulse=%b hit=%b wrap=%0d want 1 0 0 0", load_ready_o, shift_pulse_o, hit_o, wrap_count_o);
    end
  endtask

  task automatic test_random();
    int bad_here = 0;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst            = ($urandom_range(0, 199) == 0);
      tick_i         = $urandom_range(0, 1);
      en_i           = ($urandom_range(0, 3) != 0);
      speed_i        = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
      load_valid_i   = ($urandom_range(0, 15) == 0);
      load_pattern_i = 16'($urandom);
      frog_col_i     = 4'($urandom_range(0, 15));
      step();
      n_cmp++;
      if (pattern_o !== m_pattern || shift_pulse_o !== m_pulse || hit_o !== m_hit ||
          wrap_count_o !== 8'(m_wrap) || load_ready_o !== !m_hold) begin
        n_bad++;
        if (bad_here++ < 10)
          $display("FAIL random cyc %0d got pat=%h pulse=%b hit=%b wrap=%0d rdy=%b want pat=%h pulse=%b hit=%b wrap=%0d rdy=%b",
                   i, pattern_o, shift_pulse_o, hit_o, wrap_count_o, load_ready_o,
                   m_pattern, m_pulse, m_hit, m_wrap, !m_hold);
      end
    end
    rst = 1'b0; tick_i = 1'b0; load_valid_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_shift();
    test_prescaler();
    test_load_vs_tick();
    test_wrap();
    test_hit();
    test_rst_mid_hold();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
